// File: rtl/serial16_rx_if.sv
// Handshake bundle for the serial receiver: serial input side plus the
// parallel word output with its valid/ready pair and status flags.
interface serial16_rx_if #(
  parameter int WIDTH = 16
);
  logic             bit_in;
  logic             bit_valid;
  logic             start;
  logic [WIDTH-1:0] out;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             abort;
  logic             overrun;

  // master: the environment feeding bits and consuming words
  modport master (
    output bit_in, bit_valid, start, out_ready,
    input  out, out_valid, busy, abort, overrun
  );

  // slave: the receiver itself
  modport slave (
    input  bit_in, bit_valid, start, out_ready,
    output out, out_valid, busy, abort, overrun
  );
endinterface

// File: rtl/serial16_rx.sv
// Bit-serial receiver: assembles WIDTH qualified bits into a word and hands it
// to a consumer through a single holding register with valid/ready.
module serial16_rx #(
  parameter int WIDTH     = 16,
  parameter bit INVERT    = 1'b1,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  serial16_rx_if.slave bus
);
  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, RECV} state_t;

  state_t           state, state_d;
  logic [CW-1:0]    count, count_d;
  logic [WIDTH-1:0] word, word_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic             abort_q, abort_d;
  logic             overrun_q, overrun_d;
  logic             complete;

  // Position in the word of the k-th bit of a frame.
  function automatic logic [CW-1:0] bit_index(input logic [CW-1:0] k);
    return LSB_FIRST ? k : LAST - k;
  endfunction

  // NOTE: every signal gets a default before any branch, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_d     = state;
    count_d     = count;
    word_d      = word;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    abort_d     = 1'b0;
    overrun_d   = overrun_q;
    complete    = 1'b0;

    if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;

    case (state)
      IDLE: begin
        if (bus.bit_valid && bus.start) begin
          word_d                  = '0;
          word_d[bit_index('0)]   = bus.bit_in;
          count_d                 = CW'(1);
          state_d                 = RECV;
        end
      end
      RECV: begin
        if (bus.bit_valid) begin
          if (bus.start) begin
            // Restart: the partial frame is dropped and this bit opens a new one.
            word_d                = '0;
            word_d[bit_index('0)] = bus.bit_in;
            count_d               = CW'(1);
            abort_d               = 1'b1;
          end else begin
            word_d[bit_index(count)] = bus.bit_in;
            if (count == LAST) begin
              complete = 1'b1;
              count_d  = '0;
              state_d  = IDLE;
            end else begin
              count_d = count + CW'(1);
            end
          end
        end
      end
    endcase

    // A finished word lands only if the holding register is free or being
    // drained this very cycle; otherwise it is lost and overrun latches.
    if (complete) begin
      if (!out_valid_q || bus.out_ready) begin
        out_d       = INVERT ? ~word_d : word_d;
        out_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed above.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      count       <= '0;
      word        <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      abort_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state       <= state_d;
      count       <= count_d;
      word        <= word_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      abort_q     <= abort_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = (state == RECV);
  assign bus.abort     = abort_q;
  assign bus.overrun   = overrun_q;
endmodule
